pair_match_judge: RTL and testbench
===================================

// Module: pair_match_judge
// PURPOSE
//  Downstream of the in-game tile-selection FSM. Takes flipped-tile events (index + 11-bit tile code) and
//  pairs them. Blinks the two selected tile LEDs, then judges by colour field. Keeps matched tiles lit,
//  counts moves and matched pairs, and raises all_matched for the game-mode FSM.
// PARAMETERS
//  NUM_TILES     10          tiles on board (one LEDR/SW each); pairs = NUM_TILES/2
//  BLINK_CYCLES  25_000_000  clocks per blink half-period (0.5 s @ 50 MHz)
//  BLINK_HALVES  4           blink half-periods before judging (>=1)
// PORTS
//  CLOCK_50      in   1   system clock
//  reset         in   1   asynchronous reset, active-high
//  clear         in   1   synchronous game clear (quit/new game), same effect as reset
//  flip_valid    in   1   1-cycle pulse: a tile was flipped
//  flip_idx      in   4   flipped tile index, 0..NUM_TILES-1
//  flip_code     in   11  tile code {row[10:9],col[8:7],colour[6:1],flipped[0]}
//  flip_ready    out  1   1 in IDLE/ONE (flip accepted), 0 otherwise
//  led_on        out  10  LEDR pattern: matched tiles + selected tiles (blink-gated)
//  matched_mask  out  10  bit i = tile i permanently matched
//  pair_count    out  3   matched pairs, 0..NUM_TILES/2
//  move_count    out  8   completed pair attempts, saturates at 255
//  result_valid  out  1   1-cycle pulse at judgement
//  result_match  out  1   judgement outcome, valid with result_valid, held until next judgement
//  all_matched   out  1   1 while in DONE
// BEHAVIOUR
//  - Reset/clear: state IDLE; all outputs, counters, timers, stored idx/code = 0. Reset async, clear sync.
//    Both override any in-flight event, including mid-BLINK. clear has priority over flip_valid.
//  - All outputs registered or decoded from state regs; no combinational input->output path.
//  - Flip accepted only if flip_valid & flip_ready & flip_idx<NUM_TILES & !matched_mask[flip_idx].
//    Otherwise the flip is silently dropped (no state change).
//  - IDLE: accepted flip -> store idx1/code1, -> ONE. led_on[idx1] set next cycle.
//  - ONE: accepted flip with flip_idx==idx1 dropped. Otherwise:
//    store idx2/code2; move_count+1 (sat 255); timer=0, halves=0, phase=on; -> BLINK.
//  - BLINK: flip_ready=0, flips dropped. timer counts 0..BLINK_CYCLES-1.
//    On terminal count: timer=0, phase toggles, halves+1.
//    When halves reaches BLINK_HALVES -> RESOLVE. BLINK lasts exactly BLINK_HALVES*BLINK_CYCLES clocks.
//  - RESOLVE (1 cycle): match = (code1[6:1]==code2[6:1]). result_valid=1, result_match=match.
//    If match: set matched_mask[idx1], matched_mask[idx2], pair_count+1.
//    Next state DONE if the new pair_count==NUM_TILES/2, else IDLE.
//  - DONE: all_matched=1, flip_ready=0, all flips dropped; exits only via clear/reset.
//  - led_on = matched_mask | (ONE ? bit idx1 : 0) | (BLINK & phase_on ? bits idx1,idx2 : 0).
//    After a mismatch, idx1/idx2 LEDs are off the cycle after RESOLVE.
//  - Widths: idx compared unsigned 4-bit; colour compare uses bits [6:1] only (row/col/flipped ignored).
// TESTING  (bench uses BLINK_CYCLES=4, BLINK_HALVES=2)
//  1. Pulse reset mid-run -> same cycle: all outputs 0, flip_ready=1. Release, no stimulus -> outputs stay 0.
//  2. Flip idx0 (colour 1) then idx7 (colour 1) -> led_on 0x001, then 0x081 for 4 clk, 0x000 for 4 clk;
//     result_valid=1 with result_match=1; then matched_mask=0x081, led_on=0x081, pair_count=1, move_count=1.
//  3. Flip idx0 (colour 1) then idx1 (colour 2) -> result_match=0, matched_mask=0, led_on back to 0x000,
//     move_count=1, state IDLE.
//  4. Dropped flips: idx0 twice in ONE; idx12; an already-matched idx; any flip during BLINK.
//     -> no state/count change, flip_ready as specified.
//  5. Five matching pairs (0/7,1/4,2/6,3/5,8/9) -> after 5th RESOLVE: pair_count=5, matched_mask=0x3FF,
//     all_matched=1, further flips ignored. clear -> everything 0, IDLE.
//  6. 256 mismatched attempts -> move_count=255 and holds; reset asserted during BLINK -> immediate zeros,
//     no result_valid.

Source files
------------

// File: rtl/pair_match_judge.sv
// pair_match_judge
//   Pairs flipped-tile events from the tile-selection FSM. The two selected
//   tile LEDs blink, and then the pair is judged on the colour field. Matched
//   tiles stay lit. The block counts moves and matched pairs, and it flags
//   all_matched once every pair on the board has been found.
//
// Ports
//   CLOCK_50      system clock
//   reset         asynchronous reset, active-high
//   clear         synchronous game clear, same effect as reset
//   flip_valid    1-cycle pulse: a tile was flipped
//   flip_idx      flipped tile index
//   flip_code     tile code {row[10:9], col[8:7], colour[6:1], flipped[0]}
//   flip_ready    high while a flip can be accepted (IDLE / ONE)
//   led_on        matched tiles plus blink-gated selected tiles
//   matched_mask  bit i = tile i permanently matched
//   pair_count    matched pairs so far
//   move_count    completed pair attempts, saturating at 255
//   result_valid  1-cycle pulse at judgement
//   result_match  judgement outcome, held until the next judgement
//   all_matched   high while every pair is matched (DONE)
module pair_match_judge #(
  parameter int NUM_TILES    = 10,
  parameter int BLINK_CYCLES = 25_000_000,
  parameter int BLINK_HALVES = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 flip_valid,
  input  logic [3:0]           flip_idx,
  input  logic [10:0]          flip_code,
  output logic                 flip_ready,
  output logic [NUM_TILES-1:0] led_on,
  output logic [NUM_TILES-1:0] matched_mask,
  output logic [2:0]           pair_count,
  output logic [7:0]           move_count,
  output logic                 result_valid,
  output logic                 result_match,
  output logic                 all_matched
);

  localparam int TW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int HW = $clog2(BLINK_HALVES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BLINK_CYCLES - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(BLINK_HALVES - 1);
  localparam logic [3:0]    TILES4     = 4'(NUM_TILES);
  localparam logic [2:0]    PAIRS      = 3'(NUM_TILES / 2);

  typedef enum logic [2:0] {S_IDLE, S_ONE, S_BLINK, S_RESOLVE, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      idx1, idx2;
  logic [5:0]      colour1, colour2;
  logic [TW-1:0]   timer;
  logic [HW-1:0]   halves;
  logic            phase_on;
  logic            match_hold;

  logic            tile_matched;
  logic            accept, accept_first, accept_second;
  logic            blink_tc, blink_end;
  logic            colour_eq;
  logic [2:0]      pair_inc;

  // Only the colour field takes part in the judgement.
  logic unused_code;
  assign unused_code = ^{flip_code[10:7], flip_code[0]};

  function automatic logic [NUM_TILES-1:0] tile_bit(input logic [3:0] idx);
    tile_bit = '0;
    for (int i = 0; i < NUM_TILES; i++)
      if (idx == 4'(i)) tile_bit[i] = 1'b1;
  endfunction

  // Decoding through a loop avoids indexing past the mask for idx >= NUM_TILES.
  always_comb begin
    tile_matched = 1'b0;
    for (int i = 0; i < NUM_TILES; i++)
      if (flip_idx == 4'(i)) tile_matched = matched_mask[i];
  end

  assign accept        = flip_valid & flip_ready & (flip_idx < TILES4) & ~tile_matched;
  assign accept_first  = accept & (state == S_IDLE);
  assign accept_second = accept & (state == S_ONE) & (flip_idx != idx1);
  assign blink_tc      = (state == S_BLINK) & (timer == TIMER_LAST);
  assign blink_end     = blink_tc & (halves == HALF_LAST);
  assign colour_eq     = (colour1 == colour2);
  assign pair_inc      = pair_count + 3'd1;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (accept_first)  state_nxt = S_ONE;
        S_ONE:     if (accept_second) state_nxt = S_BLINK;
        S_BLINK:   if (blink_end)     state_nxt = S_RESOLVE;
        S_RESOLVE: state_nxt = (colour_eq && pair_inc == PAIRS) ? S_DONE : S_IDLE;
        S_DONE:    state_nxt = S_DONE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decode from registers only, so no input reaches an output combinationally.
  always_comb begin
    flip_ready   = (state == S_IDLE) || (state == S_ONE);
    all_matched  = (state == S_DONE);
    result_valid = (state == S_RESOLVE);
    result_match = (state == S_RESOLVE) ? colour_eq : match_hold;
    led_on       = matched_mask;
    if (state == S_ONE)
      led_on = led_on | tile_bit(idx1);
    if (state == S_BLINK && phase_on)
      led_on = led_on | tile_bit(idx1) | tile_bit(idx2);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      idx1         <= '0;
      idx2         <= '0;
      colour1      <= '0;
      colour2      <= '0;
      timer        <= '0;
      halves       <= '0;
      phase_on     <= 1'b0;
      match_hold   <= 1'b0;
      matched_mask <= '0;
      pair_count   <= '0;
      move_count   <= '0;
    end else if (clear) begin
      idx1         <= '0;
      idx2         <= '0;
      colour1      <= '0;
      colour2      <= '0;
      timer        <= '0;
      halves       <= '0;
      phase_on     <= 1'b0;
      match_hold   <= 1'b0;
      matched_mask <= '0;
      pair_count   <= '0;
      move_count   <= '0;
    end else begin
      if (accept_first) begin
        idx1    <= flip_idx;
        colour1 <= flip_code[6:1];
      end
      if (accept_second) begin
        idx2     <= flip_idx;
        colour2  <= flip_code[6:1];
        timer    <= '0;
        halves   <= '0;
        phase_on <= 1'b1;
        if (move_count != 8'hFF) move_count <= move_count + 8'd1;
      end
      if (state == S_BLINK) begin
        if (blink_tc) begin
          timer    <= '0;
          phase_on <= ~phase_on;
          halves   <= halves + HW'(1);
        end else begin
          timer <= timer + TW'(1);
        end
      end
      if (state == S_RESOLVE) begin
        match_hold <= colour_eq;
        if (colour_eq) begin
          matched_mask <= matched_mask | tile_bit(idx1) | tile_bit(idx2);
          pair_count   <= pair_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pair_match_judge.sv
module tb_pair_match_judge;

  logic        clk = 1'b0;
  logic        reset, clear, flip_valid;
  logic [3:0]  flip_idx;
  logic [10:0] flip_code;
  logic        flip_ready, result_valid, result_match, all_matched;
  logic [9:0]  led_on, matched_mask;
  logic [2:0]  pair_count;
  logic [7:0]  move_count;

  int checks = 0;
  int errors = 0;

  pair_match_judge #(.NUM_TILES(10), .BLINK_CYCLES(4), .BLINK_HALVES(2)) dut (
    .CLOCK_50(clk), .reset(reset), .clear(clear), .flip_valid(flip_valid),
    .flip_idx(flip_idx), .flip_code(flip_code), .flip_ready(flip_ready),
    .led_on(led_on), .matched_mask(matched_mask), .pair_count(pair_count),
    .move_count(move_count), .result_valid(result_valid), .result_match(result_match),
    .all_matched(all_matched)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flip(input logic [3:0] idx, input logic [5:0] colour);
    flip_valid = 1'b1;
    flip_idx   = idx;
    flip_code  = {4'b1010, colour, 1'b1};
    tick();
    flip_valid = 1'b0;
  endtask

  // Walks the 8-clock blink, checking LEDs, and leaves the bench in RESOLVE.
  task automatic blink(input string tag, input logic [9:0] on_pat, input logic [9:0] off_pat);
    logic ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (led_on !== on_pat) ok = 1'b0;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      if (led_on !== off_pat || result_valid !== 1'b0) ok = 1'b0;
      tick();
    end
    chk({tag, "_blink"}, 32'(ok), 1);
    chk({tag, "_rv"}, 32'(result_valid), 1);
  endtask

  task automatic wait_result(input string tag);
    for (int i = 0; i < 40 && result_valid !== 1'b1; i++) tick();
    chk({tag, "_rv"}, 32'(result_valid), 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_led"}, 32'(led_on), 0);
    chk({tag, "_mask"}, 32'(matched_mask), 0);
    chk({tag, "_pair"}, 32'(pair_count), 0);
    chk({tag, "_move"}, 32'(move_count), 0);
    chk({tag, "_res"}, 32'({result_valid, result_match, all_matched}), 0);
    chk({tag, "_ready"}, 32'(flip_ready), 1);
  endtask

  initial begin
    logic [9:0] mask;
    logic [3:0] pa [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
    logic [3:0] pb [5] = '{4'd7, 4'd4, 4'd6, 4'd5, 4'd9};
    logic seen_rv;

    reset = 1'b1; clear = 1'b0; flip_valid = 1'b0; flip_idx = '0; flip_code = '0;
    tick();
    // 1. reset behaviour, including async effect mid-run
    reset = 1'b0;
    flip(4'd0, 6'd1);
    chk("t1_one_led", 32'(led_on), 'h001);
    #2 reset = 1'b1;
    #1 check_zero("t1_async");
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check_zero("t1_idle");

    // 2. matching pair 0/7
    flip(4'd0, 6'd1);
    chk("t2_one_led", 32'(led_on), 'h001);
    flip(4'd7, 6'd1);
    chk("t2_ready_blink", 32'(flip_ready), 0);
    chk("t2_move_blink", 32'(move_count), 1);
    blink("t2", 10'h081, 10'h000);
    chk("t2_match", 32'(result_match), 1);
    chk("t2_mask_at_resolve", 32'(matched_mask), 0);
    tick();
    chk("t2_mask", 32'(matched_mask), 'h081);
    chk("t2_led", 32'(led_on), 'h081);
    chk("t2_pair", 32'(pair_count), 1);
    chk("t2_move", 32'(move_count), 1);
    chk("t2_rv_low", 32'({result_valid, result_match}), 'b01);

    // 3. mismatched pair 0/1 after clear (row/col bits differ from colour)
    clear = 1'b1; tick(); clear = 1'b0;
    check_zero("t3_clear");
    flip(4'd0, 6'd1);
    flip(4'd1, 6'd2);
    blink("t3", 10'h003, 10'h000);
    chk("t3_match", 32'(result_match), 0);
    tick();
    chk("t3_mask", 32'(matched_mask), 0);
    chk("t3_led", 32'(led_on), 0);
    chk("t3_move", 32'(move_count), 1);
    chk("t3_idle", 32'(flip_ready), 1);

    // 4. dropped flips
    flip(4'd0, 6'd1);
    flip(4'd0, 6'd1);
    chk("t4_same_led", 32'(led_on), 'h001);
    chk("t4_same_ready", 32'(flip_ready), 1);
    flip(4'd12, 6'd1);
    chk("t4_range_led", 32'(led_on), 'h001);
    chk("t4_range_move", 32'(move_count), 1);
    flip(4'd1, 6'd1);
    chk("t4_blink_move", 32'(move_count), 2);
    flip(4'd2, 6'd1);
    chk("t4_inblink_ready", 32'(flip_ready), 0);
    chk("t4_inblink_led", 32'(led_on), 'h003);
    chk("t4_inblink_move", 32'(move_count), 2);
    wait_result("t4a");
    chk("t4a_match", 32'(result_match), 1);
    tick();
    chk("t4a_mask", 32'(matched_mask), 'h003);
    flip(4'd0, 6'd1);
    chk("t4_matched_led", 32'(led_on), 'h003);
    flip(4'd4, 6'd3);
    chk("t4_first_ready", 32'(flip_ready), 1);
    chk("t4_first_led", 32'(led_on), 'h013);
    flip(4'd5, 6'd3);
    wait_result("t4b");
    tick();
    chk("t4b_mask", 32'(matched_mask), 'h033);
    chk("t4b_pair", 32'(pair_count), 2);
    chk("t4b_move", 32'(move_count), 3);

    // 5. full board
    clear = 1'b1; tick(); clear = 1'b0;
    mask = '0;
    for (int k = 0; k < 5; k++) begin
      chk("t5_alldone_before", 32'(all_matched), 0);
      flip(pa[k], 6'(k + 10));
      flip(pb[k], 6'(k + 10));
      blink("t5", mask | (10'd1 << pa[k]) | (10'd1 << pb[k]), mask);
      chk("t5_match", 32'(result_match), 1);
      mask = mask | (10'd1 << pa[k]) | (10'd1 << pb[k]);
      tick();
    end
    chk("t5_pair", 32'(pair_count), 5);
    chk("t5_mask", 32'(matched_mask), 'h3FF);
    chk("t5_all", 32'(all_matched), 1);
    chk("t5_ready", 32'(flip_ready), 0);
    chk("t5_move", 32'(move_count), 5);
    flip(4'd0, 6'd1);
    flip(4'd1, 6'd1);
    tick();
    chk("t5_ignored", 32'({all_matched, matched_mask, move_count}), {1'b1, 10'h3FF, 8'd5});
    clear = 1'b1; tick(); clear = 1'b0;
    check_zero("t5_clear");

    // 6. move counter saturation and reset during BLINK
    for (int k = 0; k < 256; k++) begin
      flip(4'd0, 6'd1);
      flip(4'd1, 6'd2);
      wait_result("t6");
      tick();
      if (k == 254) chk("t6_move_255", 32'(move_count), 255);
    end
    chk("t6_move_hold", 32'(move_count), 255);
    chk("t6_mask", 32'(matched_mask), 0);
    flip(4'd0, 6'd1);
    flip(4'd1, 6'd1);
    chk("t6_move_sat_blink", 32'(move_count), 255);
    tick(); tick();
    #2 reset = 1'b1;
    #1 check_zero("t6_async");
    tick();
    reset = 1'b0;
    seen_rv = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (result_valid !== 1'b0) seen_rv = 1'b1;
      tick();
    end
    chk("t6_no_result", 32'(seen_rv), 0);
    check_zero("t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
